// File: rtl/fu_pkg.sv
// Shared types for the functional-unit issue path: opcodes, issue FSM states and request payload.
package fu_pkg;

  localparam int unsigned FU_DATA_W = 64;
  localparam int unsigned FU_OPC_W  = 5;
  localparam int unsigned FU_TAG_W  = 4;

  typedef logic [FU_OPC_W-1:0] fu_opcode_t;

  // Opcodes understood by the FPU (0x00-0x0F) and the vector unit (0x10-0x1F)
  localparam fu_opcode_t FU_OP_FADD = 5'h00;
  localparam fu_opcode_t FU_OP_FMUL = 5'h01;
  localparam fu_opcode_t FU_OP_FDIV = 5'h02;
  localparam fu_opcode_t FU_OP_VADD = 5'h10;
  localparam fu_opcode_t FU_OP_VMUL = 5'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fu_issue_state_e;

  typedef struct packed {
    logic [FU_DATA_W-1:0] op_a;
    logic [FU_DATA_W-1:0] op_b;
    fu_opcode_t           opcode;
    logic [FU_TAG_W-1:0]  tag;
  } fu_req_t;

  function automatic logic [31:0] fu_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fu_req_fifo.sv
// DEPTH-entry synchronous request FIFO; full flag is registered so it never sees a same-cycle pop.
module fu_req_fifo
  import fu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fu_req_t                  wdata_i,
  input  logic                     pop_i,
  output fu_req_t                  rdata_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fu_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q;
  logic               do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & (count_q != '0);
  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Payload storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/fu_issue_ctrl.sv
// Issues buffered operand requests one at a time to an FPU/vector unit and returns tagged results.
// Optional FU_ISSUE_PERF_EN adds saturating issue/timeout counters.
module fu_issue_ctrl
  import fu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = FU_TAG_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_op_a,
  input  logic [63:0]       req_op_b,
  input  logic [4:0]        req_opcode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              fu_req,
  output logic [63:0]       fu_op_a,
  output logic [63:0]       fu_op_b,
  output logic [4:0]        fu_opcode,
  input  logic [63:0]       fu_result,
  input  logic              fu_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_timeout
`ifdef FU_ISSUE_PERF_EN
 ,output logic [31:0]       perf_issued,
  output logic [31:0]       perf_timeouts
`endif
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1;
  localparam int unsigned FCNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  fu_issue_state_e   state_q, state_d;
  fu_req_t           fifo_wdata, fifo_rdata;
  logic              fifo_push, fifo_pop, fifo_full;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              timeout_c;

  logic [63:0]       op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              fu_req_q, fu_req_d, rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;

  assign fifo_push  = req_valid & ~fifo_full;
  assign fifo_wdata = '{op_a: req_op_a, op_b: req_op_b, opcode: req_opcode,
                        tag: FU_TAG_W'(req_tag)};

  fu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A unit result in the last counted cycle still beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_cnt != '0) state_d = WAIT;
      WAIT:    if (fu_valid || (wait_cnt_q == TO_LAST)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    tag_d      = tag_q;
    result_d   = result_q;
    rsp_to_d   = rsp_to_q;
    wait_cnt_d = wait_cnt_q;
    fifo_pop   = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == WAIT) begin
          fifo_pop   = 1'b1;
          op_a_d     = fifo_rdata.op_a;
          op_b_d     = fifo_rdata.op_b;
          opcode_d   = fifo_rdata.opcode;
          tag_d      = TAG_W'(fifo_rdata.tag);
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (fu_valid) begin
          result_d = fu_result;
          rsp_to_d = 1'b0;
        end else if (wait_cnt_q == TO_LAST) begin
          result_d  = '0;
          rsp_to_d  = 1'b1;
          timeout_c = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    fu_req_d    = (state_d == WAIT);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      rsp_to_q    <= 1'b0;
      wait_cnt_q  <= '0;
      fu_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      rsp_to_q    <= rsp_to_d;
      wait_cnt_q  <= wait_cnt_d;
      fu_req_q    <= fu_req_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready   = ~fifo_full;
  assign fu_req      = fu_req_q;
  assign fu_op_a     = op_a_q;
  assign fu_op_b     = op_b_q;
  assign fu_opcode   = opcode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_tag     = tag_q;
  assign rsp_timeout = rsp_to_q;

`ifdef FU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_timeouts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q   <= '0;
      perf_timeouts_q <= '0;
    end else begin
      if (fifo_pop)  perf_issued_q   <= fu_sat_inc(perf_issued_q);
      if (timeout_c) perf_timeouts_q <= fu_sat_inc(perf_timeouts_q);
    end
  end

  assign perf_issued   = perf_issued_q;
  assign perf_timeouts = perf_timeouts_q;
`endif

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Scoreboard bench for fu_issue_ctrl with a lane-add vector unit model of programmable latency.
module tb_fu_issue_ctrl;
  import fu_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk, rst_n;
  logic             req_valid, req_ready;
  logic [63:0]      req_op_a, req_op_b;
  logic [4:0]       req_opcode;
  logic [TAG_W-1:0] req_tag;
  logic             fu_req, fu_valid;
  logic [63:0]      fu_op_a, fu_op_b, fu_result;
  logic [4:0]       fu_opcode;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [63:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
`ifdef FU_ISSUE_PERF_EN
  logic [31:0]      perf_issued, perf_timeouts;
`endif

  typedef struct {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   fu_delay = 0;
  int   wcnt;

  fu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_opcode(req_opcode), .req_tag(req_tag),
    .fu_req(fu_req), .fu_op_a(fu_op_a), .fu_op_b(fu_op_b), .fu_opcode(fu_opcode),
    .fu_result(fu_result), .fu_valid(fu_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
`ifdef FU_ISSUE_PERF_EN
   ,.perf_issued(perf_issued), .perf_timeouts(perf_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] vadd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
    return r;
  endfunction

  // Vector unit: answers after fu_delay cycles of fu_req (-1 never answers)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else        wcnt <= fu_req ? wcnt + 1 : 0;
  end
  assign fu_valid  = fu_req && (wcnt == fu_delay);
  assign fu_result = vadd(fu_op_a, fu_op_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_rsp: got tag %0d expected none", rsp_tag);
      end else begin
        e = sb.pop_front();
        check("rsp_result", rsp_result, e.result);
        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                      input logic [63:0] er, input logic eto, input int bound, input bit must,
                      output bit acc);
    acc = 1'b0;
    req_op_a = a; req_op_b = b; req_opcode = FU_OP_VADD; req_tag = tag;
    req_valid = 1'b1;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        sb.push_back('{er, tag, eto});
        acc = 1'b1;
      end
    end
    if (!acc) @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!acc && must) begin
      vectors++;
      errors++;
      $display("FAIL push_accept: got no acceptance for tag %0d expected acceptance", tag);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    sync();
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d responses pending expected 0", sb.size());
    end
  endtask

  // Counts fu_req-high cycles until rsp_valid appears
  task automatic wait_cycles(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else if (fu_req) n++;
    end
    if (!seen) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_op_a = '0; req_op_b = '0;
    req_opcode = '0; req_tag = '0; rsp_ready = 1'b1;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_fu_req", 64'(fu_req), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_fu_op_a", fu_op_a, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    sync();

    // Single op with latency checks
    push(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 4'd3,
         64'h0011_0022_0033_0044, 1'b0, 10, 1'b1, acc);
    @(negedge clk);
    check("lat_fu_req_e0", 64'(fu_req), 64'd0);
    @(negedge clk);
    check("lat_fu_req_e1", 64'(fu_req), 64'd1);
    check("lat_rsp_valid_e1", 64'(rsp_valid), 64'd0);
    check("lat_fu_op_a", fu_op_a, 64'h0001_0002_0003_0004);
    check("lat_fu_opcode", 64'(fu_opcode), 64'(FU_OP_VADD));
    @(negedge clk);
    check("lat_rsp_valid_e2", 64'(rsp_valid), 64'd1);
    drain();

    // Fill: DEPTH queued plus one in flight
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push({4{16'(i)}}, 64'h0100_0100_0100_0100, TAG_W'(i),
           {4{16'(16'h0100 + i)}}, 1'b0, 3, 1'b0, acc);
      if (acc) n++;
    end
    check("fill_accepted", 64'(n), 64'(DEPTH + 1));
    check("fill_req_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    drain();

    // Timeout, then a result in the very last counted cycle
    fu_delay = -1;
    push(64'h1, 64'h2, 4'd7, 64'd0, 1'b1, 10, 1'b1, acc);
    wait_cycles(n);
    check("to_wait_cycles", 64'(n), 64'(TIMEOUT));
    drain();
    fu_delay = TIMEOUT - 1;
    push(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 4'd8,
         64'h3333_3333_3333_3333, 1'b0, 10, 1'b1, acc);
    wait_cycles(n);
    check("late_wait_cycles", 64'(n), 64'(TIMEOUT));
    drain();

    // Backpressure: response held, nothing else issued
    fu_delay = 0;
    rsp_ready = 1'b0;
    push(64'h5, 64'h6, 4'd9, 64'hB, 1'b0, 10, 1'b1, acc);
    push(64'hFFFF_0000_0000_0001, 64'h0001_0000_0000_0001, 4'd10,
         64'h0000_0000_0000_0002, 1'b0, 10, 1'b1, acc);
    wait_cycles(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_result", rsp_result, 64'hB);
      check("bp_rsp_tag", 64'(rsp_tag), 64'd9);
      check("bp_fu_req", 64'(fu_req), 64'd0);
    end
    sync();
    rsp_ready = 1'b1;
    drain();

    // Reset while the unit stalls with two requests queued
    fu_delay = -1;
    for (int i = 1; i <= 3; i++)
      push(64'(i), 64'(i), TAG_W'(i), 64'd0, 1'b1, 10, 1'b1, acc);
    sync(); sync();
    check("pre_rst_fu_req", 64'(fu_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_fu_req", 64'(fu_req), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    sync();
    fu_delay = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_fu_req", 64'(fu_req), 64'd0);
    end
    sync();

`ifdef FU_ISSUE_PERF_EN
    for (int i = 0; i < 5; i++)
      push(64'(i), 64'h1, TAG_W'(i), 64'(i + 1), 1'b0, 10, 1'b1, acc);
    drain();
    fu_delay = -1;
    for (int i = 5; i < 7; i++)
      push(64'(i), 64'h1, TAG_W'(i), 64'd0, 1'b1, 10, 1'b1, acc);
    drain();
    check("perf_issued", 64'(perf_issued), 64'd7);
    check("perf_timeouts", 64'(perf_timeouts), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
